// File: rtl/turn_controller.sv
// turn_controller: tic-tac-toe turn sequencer with a shadow board for win/draw detection.
// Optional feature macro: TURN_TIMEOUT_EN (per-turn idle timeout with forfeit).
`default_nettype none

`ifndef CELL_X
`define CELL_X 2'd1
`endif
`ifndef CELL_O
`define CELL_O 2'd2
`endif
`ifndef INDEX_T
`define INDEX_T logic [3:0]
`endif
`ifndef STATE_T
`define STATE_T logic [1:0]
`endif
`ifndef FLAG_T
`define FLAG_T logic
`endif

module turn_controller #(
   parameter int FIRST_O        = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_game,
   input  logic        x_valid,
   input  `INDEX_T     x_loc,
   input  logic        o_valid,
   input  `INDEX_T     o_loc,
   output logic        x_ack,
   output logic        o_ack,
   output logic        x_nack,
   output logic        o_nack,
   output `INDEX_T     update_loc,
   output `STATE_T     update_val,
   output `FLAG_T      submit,
   output `FLAG_T      board_reset,
   output logic        turn,
   output logic        game_over,
   output `STATE_T     winner,
   output logic [3:0]  move_count,
   output logic        timeout
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state;
   logic [8:0][1:0]   cells;

   logic              cur_valid;
   logic [3:0]        cur_loc;
   logic [1:0]        mover;
   logic              cell_free;
   logic              legal;
   logic [8:0]        mine;
   logic              win;

   always_comb begin
      cur_valid = turn ? o_valid : x_valid;
      cur_loc   = turn ? o_loc : x_loc;
      mover     = turn ? `CELL_O : `CELL_X;
      cell_free = 1'b0;
      if (cur_loc <= 4'd8) begin
         cell_free = (cells[cur_loc] == 2'd0);
      end
      legal = cur_valid && cell_free;
      for (int i = 0; i < 9; i++) begin
         mine[i] = (cells[i] == mover);
      end
      win = (&mine[2:0]) || (&mine[5:3]) || (&mine[8:6]) ||
            (mine[0] && mine[3] && mine[6]) ||
            (mine[1] && mine[4] && mine[7]) ||
            (mine[2] && mine[5] && mine[8]) ||
            (mine[0] && mine[4] && mine[8]) ||
            (mine[2] && mine[4] && mine[6]);
   end

`ifdef TURN_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] idle_cnt;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cells       <= '0;
         turn        <= (FIRST_O != 0);
         move_count  <= 4'd0;
         game_over   <= 1'b0;
         winner      <= 2'd0;
         x_ack       <= 1'b0;
         o_ack       <= 1'b0;
         x_nack      <= 1'b0;
         o_nack      <= 1'b0;
         update_loc  <= '0;
         update_val  <= '0;
         submit      <= 1'b0;
         board_reset <= 1'b0;
         timeout     <= 1'b0;
`ifdef TURN_TIMEOUT_EN
         idle_cnt    <= 8'd0;
`endif
      end else begin
         x_ack       <= 1'b0;
         o_ack       <= 1'b0;
         x_nack      <= 1'b0;
         o_nack      <= 1'b0;
         submit      <= 1'b0;
         board_reset <= 1'b0;
         timeout     <= 1'b0;
         if (new_game) begin
            // Same-cycle requests are dropped silently; a move in flight is aborted.
            board_reset <= 1'b1;
            cells       <= '0;
            turn        <= (FIRST_O != 0);
            move_count  <= 4'd0;
            game_over   <= 1'b0;
            winner      <= 2'd0;
            state       <= S_IDLE;
`ifdef TURN_TIMEOUT_EN
            idle_cnt    <= 8'd0;
`endif
         end else begin
            // Anything other than the current player's request in IDLE is refused outright.
            if (x_valid && !(state == S_IDLE && !turn)) x_nack <= 1'b1;
            if (o_valid && !(state == S_IDLE && turn))  o_nack <= 1'b1;
            case (state)
               S_IDLE: begin
                  if (legal) begin
                     if (turn) o_ack <= 1'b1;
                     else      x_ack <= 1'b1;
                     update_loc     <= cur_loc;
                     update_val     <= mover;
                     submit         <= 1'b1;
                     cells[cur_loc] <= mover;
                     state          <= S_ISSUE;
`ifdef TURN_TIMEOUT_EN
                     idle_cnt       <= 8'd0;
`endif
                  end else begin
                     if (cur_valid) begin
                        if (turn) o_nack <= 1'b1;
                        else      x_nack <= 1'b1;
                     end
`ifdef TURN_TIMEOUT_EN
                     if (idle_cnt == TO_LAST) begin
                        timeout  <= 1'b1;
                        turn     <= ~turn;
                        idle_cnt <= 8'd0;
                     end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                     end
`endif
                  end
               end
               S_ISSUE: begin
                  move_count <= move_count + 4'd1;
                  state      <= S_CHECK;
               end
               S_CHECK: begin
                  if (win) begin
                     winner    <= mover;
                     game_over <= 1'b1;
                     state     <= S_DONE;
                  end else if (move_count == 4'd9) begin
                     winner    <= 2'd0;
                     game_over <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     turn  <= ~turn;
                     state <= S_IDLE;
`ifdef TURN_TIMEOUT_EN
                     idle_cnt <= 8'd0;
`endif
                  end
               end
               S_DONE: begin
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed self-checking bench for turn_controller.
`default_nettype none

module tb_turn_controller;

`ifdef TURN_TIMEOUT_EN
   localparam int TO_CYC = 4;
`else
   localparam int TO_CYC = 255;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       new_game = 1'b0;
   logic       x_valid = 1'b0;
   logic [3:0] x_loc = 4'd0;
   logic       o_valid = 1'b0;
   logic [3:0] o_loc = 4'd0;
   logic       x_ack, o_ack, x_nack, o_nack;
   logic [3:0] update_loc;
   logic [1:0] update_val;
   logic       submit, board_reset, turn, game_over;
   logic [1:0] winner;
   logic [3:0] move_count;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] obs;   // {x_ack,o_ack,x_nack,o_nack,submit,update_loc,update_val}
   logic        s_br;

   turn_controller #(.FIRST_O(0), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .reset(reset), .new_game(new_game),
      .x_valid(x_valid), .x_loc(x_loc), .o_valid(o_valid), .o_loc(o_loc),
      .x_ack(x_ack), .o_ack(o_ack), .x_nack(x_nack), .o_nack(o_nack),
      .update_loc(update_loc), .update_val(update_val), .submit(submit),
      .board_reset(board_reset), .turn(turn), .game_over(game_over),
      .winner(winner), .move_count(move_count), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // One-cycle request from a player; obs captured the cycle after sampling.
   task automatic drive(input bit pl, input logic [3:0] loc);
      @(negedge clk);
      if (pl) begin o_valid = 1'b1; o_loc = loc; end
      else    begin x_valid = 1'b1; x_loc = loc; end
      @(negedge clk);
      obs = {x_ack, o_ack, x_nack, o_nack, submit, update_loc, update_val};
      x_valid = 1'b0;
      o_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_new_game();
      @(negedge clk);
      new_game = 1'b1;
      @(negedge clk);
      s_br = board_reset;
      new_game = 1'b0;
   endtask

   task automatic test_reset();
      logic [22:0] v;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      v = {turn, move_count, game_over, winner, x_ack, o_ack, x_nack, o_nack,
           submit, board_reset, update_loc, update_val, timeout};
      n_checks++;
      if (v !== 23'd0) begin n_fail++; $display("FAIL reset_in: got %h required 0", v); end
      reset = 1'b1;
      @(negedge clk);
      v = {turn, move_count, game_over, winner, x_ack, o_ack, x_nack, o_nack,
           submit, board_reset, update_loc, update_val, timeout};
      n_checks++;
      if (v !== 23'd0) begin n_fail++; $display("FAIL reset_out: got %h required 0", v); end
   endtask

   task automatic test_x_wins();
      int locs[5] = '{0, 3, 1, 4, 2};
      logic [10:0] exp;
      for (int i = 0; i < 5; i++) begin
         drive(i % 2 == 1, 4'(locs[i]));
         exp = {i % 2 == 0, i % 2 == 1, 2'b00, 1'b1, 4'(locs[i]), (i % 2 == 1) ? 2'd2 : 2'd1};
         n_checks++;
         if (obs !== exp) begin n_fail++; $display("FAIL win_move%0d: got %h required %h", i, obs, exp); end
         settle();
      end
      n_checks++;
      if ({game_over, winner, move_count} !== {1'b1, 2'd1, 4'd5}) begin
         n_fail++;
         $display("FAIL win_result: got go=%b w=%0d mc=%0d required go=1 w=1 mc=5", game_over, winner, move_count);
      end
      drive(1'b0, 4'd7);
      n_checks++;
      if (obs[10:6] !== 5'b00100) begin n_fail++; $display("FAIL win_done_nack: got %b required 00100", obs[10:6]); end
   endtask

   task automatic test_illegal();
      pulse_new_game();
      n_checks++;
      if ({s_br, move_count, turn, game_over, winner} !== {1'b1, 4'd0, 1'b0, 1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL newgame_clear: got br=%b mc=%0d t=%b go=%b w=%0d required 1 0 0 0 0", s_br, move_count, turn, game_over, winner);
      end
      n_checks++;
      @(negedge clk);
      if (board_reset !== 1'b0) begin n_fail++; $display("FAIL board_reset_width: got %b required 0", board_reset); end
      drive(1'b0, 4'd0);
      n_checks++;
      if (obs !== {5'b10001, 4'd0, 2'd1}) begin n_fail++; $display("FAIL ill_x0: got %h required %h", obs, {5'b10001, 4'd0, 2'd1}); end
      settle();
      drive(1'b1, 4'd0);
      n_checks++;
      if ({obs[10:6], turn} !== 6'b000101) begin n_fail++; $display("FAIL ill_occupied: got %b required 000101", {obs[10:6], turn}); end
      drive(1'b0, 4'd5);
      n_checks++;
      if (obs[10:6] !== 5'b00100) begin n_fail++; $display("FAIL ill_out_of_turn: got %b required 00100", obs[10:6]); end
      drive(1'b1, 4'd9);
      n_checks++;
      if (obs[10:6] !== 5'b00010) begin n_fail++; $display("FAIL ill_loc9: got %b required 00010", obs[10:6]); end
      drive(1'b1, 4'd8);
      n_checks++;
      if (obs !== {5'b01001, 4'd8, 2'd2}) begin n_fail++; $display("FAIL ill_o8: got %h required %h", obs, {5'b01001, 4'd8, 2'd2}); end
      settle();
   endtask

   task automatic test_both_valid();
      int subs = 0;
      pulse_new_game();
      @(negedge clk);
      x_valid = 1'b1; x_loc = 4'd4;
      o_valid = 1'b1; o_loc = 4'd5;
      @(negedge clk);
      obs = {x_ack, o_ack, x_nack, o_nack, submit, update_loc, update_val};
      x_valid = 1'b0; o_valid = 1'b0;
      n_checks++;
      if (obs !== {5'b10011, 4'd4, 2'd1}) begin n_fail++; $display("FAIL both_valid: got %h required %h", obs, {5'b10011, 4'd4, 2'd1}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (submit) subs++;
      end
      n_checks++;
      if (subs !== 0 || turn !== 1'b1) begin n_fail++; $display("FAIL both_single_submit: got extra=%0d turn=%b required 0 1", subs, turn); end
   endtask

   task automatic test_draw();
      int dl[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
      logic [10:0] exp;
      int bad = 0;
      pulse_new_game();
      for (int i = 0; i < 9; i++) begin
         drive(i % 2 == 1, 4'(dl[i]));
         exp = {i % 2 == 0, i % 2 == 1, 2'b00, 1'b1, 4'(dl[i]), (i % 2 == 1) ? 2'd2 : 2'd1};
         if (obs !== exp) begin bad++; $display("FAIL draw_move%0d: got %h required %h", i, obs, exp); end
         settle();
      end
      n_checks++;
      if (bad != 0) n_fail++;
      n_checks++;
      if ({game_over, winner, move_count} !== {1'b1, 2'd0, 4'd9}) begin
         n_fail++;
         $display("FAIL draw_result: got go=%b w=%0d mc=%0d required go=1 w=0 mc=9", game_over, winner, move_count);
      end
      @(negedge clk);
      x_valid = 1'b1; o_valid = 1'b1; x_loc = 4'd4; o_loc = 4'd4;
      @(negedge clk);
      obs = {x_ack, o_ack, x_nack, o_nack, submit, update_loc, update_val};
      x_valid = 1'b0; o_valid = 1'b0;
      n_checks++;
      if (obs[10:6] !== 5'b00110) begin n_fail++; $display("FAIL draw_done_nack: got %b required 00110", obs[10:6]); end
   endtask

   task automatic test_new_game_collision();
      logic [22:0] v;
      @(negedge clk);
      new_game = 1'b1; x_valid = 1'b1; x_loc = 4'd4;
      @(negedge clk);
      obs = {x_ack, o_ack, x_nack, o_nack, submit, update_loc, update_val};
      s_br = board_reset;
      new_game = 1'b0; x_valid = 1'b0;
      n_checks++;
      if ({obs[10:6], s_br, turn} !== 7'b0000010) begin n_fail++; $display("FAIL ng_collide: got %b required 0000010", {obs[10:6], s_br, turn}); end
      drive(1'b0, 4'd4);
      n_checks++;
      if (obs !== {5'b10001, 4'd4, 2'd1}) begin n_fail++; $display("FAIL ng_shadow_empty: got %h required %h", obs, {5'b10001, 4'd4, 2'd1}); end
      // now in ISSUE: abort the move with new_game
      new_game = 1'b1;
      @(negedge clk);
      s_br = board_reset;
      new_game = 1'b0;
      settle();
      n_checks++;
      if ({s_br, move_count, turn, game_over} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL ng_abort_issue: got br=%b mc=%0d t=%b go=%b required 1 0 0 0", s_br, move_count, turn, game_over);
      end
      drive(1'b0, 4'd4);
      n_checks++;
      if (obs !== {5'b10001, 4'd4, 2'd1}) begin n_fail++; $display("FAIL ng_replay: got %h required %h", obs, {5'b10001, 4'd4, 2'd1}); end
      #2 reset = 1'b0;
      #1;
      v = {turn, move_count, game_over, winner, x_ack, o_ack, x_nack, o_nack,
           submit, board_reset, update_loc, update_val, timeout};
      n_checks++;
      if (v !== 23'd0) begin n_fail++; $display("FAIL async_reset_issue: got %h required 0", v); end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({move_count, turn, submit} !== 6'd0) begin n_fail++; $display("FAIL post_reset_idle: got %b required 0", {move_count, turn, submit}); end
   endtask

`ifdef TURN_TIMEOUT_EN
   task automatic test_timeout();
      bit seen = 1'b0;
      bit wrote = 1'b0;
      pulse_new_game();
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         if (submit) wrote = 1'b1;
         if (timeout) seen = 1'b1;
      end
      n_checks++;
      if ({seen, turn, wrote} !== 3'b110) begin n_fail++; $display("FAIL timeout_forfeit: got %b required 110", {seen, turn, wrote}); end
   endtask
`endif

   initial begin
      test_reset();
      test_x_wins();
      test_illegal();
      test_both_valid();
      test_draw();
      test_new_game_collision();
`ifdef TURN_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
